// File: rtl/rx_chan_packer.sv
// Receive-path packer: snapshots enabled DDC channels on a strobe, serialises them
// into 32-bit words (earliest sample in the MS bits) and buffers them in a FIFO.
module rx_chan_packer #(
  parameter int NUM_CH    = 4,
  parameter int SAMPLE_W  = 16,
  parameter int DEPTH     = 4096,
  parameter int PKT_WORDS = 2048
) (
  input  logic                       rx_clk,
  input  logic                       reset,
  input  logic [NUM_CH-1:0]          channels,
  input  logic [NUM_CH*SAMPLE_W-1:0] ch_data,
  input  logic                       rxstrobe,
  input  logic                       clear_status,
  input  logic                       rd_req,
  output logic [31:0]                rd_data,
  output logic                       rd_valid,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       have_pkt_rdy,
  output logic                       rx_overrun,
  output logic                       rx_underrun
);
  localparam int LANES = 32 / SAMPLE_W;
  localparam int AW    = $clog2(DEPTH);
  localparam int LNW   = $clog2(LANES) + 1;
  localparam int CW    = $clog2(NUM_CH > 1 ? NUM_CH : 2);

  typedef enum logic {S_IDLE, S_SCAN} state_t;

  state_t                     state_q, state_d;
  logic [NUM_CH-1:0]          pend_q, pend_d;
  logic [NUM_CH*SAMPLE_W-1:0] snap_q, snap_d;
  logic [31:0]                acc_q, acc_d;
  logic [LNW-1:0]             lane_q, lane_d;
  logic [AW-1:0]              wr_ptr_q, rd_ptr_q;
  logic [AW:0]                count_q, count_d;
  logic [31:0]                rd_data_q;
  logic                       rd_valid_q, pkt_q, ovr_q, und_q;
  logic [31:0]                mem [DEPTH];

  logic [SAMPLE_W-1:0] samp [NUM_CH];
  logic [CW-1:0]       sel;
  logic [NUM_CH-1:0]   low_bit, rest;
  logic                last, strobe_live, consume, accept, drop_strobe;
  logic                push, pop, push_ok;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_samp
      assign samp[gi] = snap_q[gi*SAMPLE_W +: SAMPLE_W];
    end
  endgenerate

  // Lowest pending channel is served first; 'rest' is what remains after it.
  always_comb begin
    sel = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (pend_q[k]) sel = CW'(k);
    end
  end

  assign low_bit     = pend_q & (~pend_q + 1'b1);
  assign rest        = pend_q & ~low_bit;
  assign last        = (rest == '0);
  assign strobe_live = rxstrobe && (channels != '0);

  always_ff @(posedge rx_clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (strobe_live) state_d = S_SCAN;
      S_SCAN:  if (last && !strobe_live) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    consume     = (state_q == S_SCAN);
    accept      = strobe_live && ((state_q == S_IDLE) || last);
    drop_strobe = strobe_live && !accept;
  end

  always_comb begin
    pend_d = pend_q;
    snap_d = snap_q;
    if (accept) begin
      pend_d = channels;
      snap_d = ch_data;
    end else if (consume) begin
      pend_d = rest;
    end
  end

  always_comb begin
    acc_d  = acc_q;
    lane_d = lane_q;
    push   = 1'b0;
    if (consume) begin
      acc_d = (acc_q << SAMPLE_W) | 32'(samp[sel]);
      if (lane_q == LNW'(LANES - 1)) begin
        push   = 1'b1;
        lane_d = '0;
      end else begin
        lane_d = lane_q + 1'b1;
      end
    end
  end

  // A full FIFO still takes a word when a pop frees the head slot on the same edge.
  assign pop     = rd_req && (count_q != '0);
  assign push_ok = push && ((count_q != (AW+1)'(DEPTH)) || pop);

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop)      count_d = count_q + 1'b1;
    else if (!push_ok && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge rx_clk) begin
    if (reset) begin
      pend_q     <= '0;
      snap_q     <= '0;
      acc_q      <= '0;
      lane_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      pkt_q      <= 1'b0;
      ovr_q      <= 1'b0;
      und_q      <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      snap_q     <= snap_d;
      acc_q      <= acc_d;
      lane_q     <= lane_d;
      count_q    <= count_d;
      rd_valid_q <= pop;
      pkt_q      <= (count_d >= (AW+1)'(PKT_WORDS));
      ovr_q      <= (ovr_q & ~clear_status) | drop_strobe | (push && !push_ok);
      und_q      <= (und_q & ~clear_status) | (rd_req && !pop);
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q  <= rd_ptr_q + 1'b1;
        rd_data_q <= mem[rd_ptr_q];
      end
    end
  end

  always_ff @(posedge rx_clk) begin
    if (push_ok) mem[wr_ptr_q] <= acc_d;
  end

  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign level        = count_q;
  assign have_pkt_rdy = pkt_q;
  assign rx_overrun   = ovr_q;
  assign rx_underrun  = und_q;
endmodule

// File: tb/tb_rx_chan_packer.sv
// Directed bench for rx_chan_packer with a 4-word FIFO and a packet threshold of 3.
module tb_rx_chan_packer;
  logic        rx_clk = 1'b0;
  logic        reset, rxstrobe, clear_status, rd_req;
  logic [3:0]  channels;
  logic [63:0] ch_data;
  logic [31:0] rd_data;
  logic        rd_valid, have_pkt_rdy, rx_overrun, rx_underrun;
  logic [2:0]  level;
  int          vec_cnt = 0;
  int          miss_cnt = 0;

  rx_chan_packer #(.NUM_CH(4), .SAMPLE_W(16), .DEPTH(4), .PKT_WORDS(3)) dut (
    .rx_clk(rx_clk), .reset(reset), .channels(channels), .ch_data(ch_data),
    .rxstrobe(rxstrobe), .clear_status(clear_status), .rd_req(rd_req),
    .rd_data(rd_data), .rd_valid(rd_valid), .level(level),
    .have_pkt_rdy(have_pkt_rdy), .rx_overrun(rx_overrun), .rx_underrun(rx_underrun)
  );

  always #5 rx_clk = ~rx_clk;

  task automatic tick();
    @(posedge rx_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      miss_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %-16s observed %h expected %h", tag, obs, exp);
  endtask

  task automatic strobe(input logic [3:0] mask, input logic [63:0] data);
    channels = mask;
    ch_data  = data;
    rxstrobe = 1'b1;
    tick();
    rxstrobe = 1'b0;
  endtask

  task automatic read_word(input string tag, input logic [31:0] exp_word, input logic [31:0] exp_lvl);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    chk({tag, "_data"}, rd_data, exp_word);
    chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
    chk({tag, "_level"}, 32'(level), exp_lvl);
  endtask

  initial begin
    reset = 1'b1; rxstrobe = 1'b0; clear_status = 1'b0; rd_req = 1'b0;
    channels = '0; ch_data = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_level", 32'(level), 0);
    chk("rst_rdata", rd_data, 0);
    chk("rst_rvalid", 32'(rd_valid), 0);
    chk("rst_pkt", 32'(have_pkt_rdy), 0);
    chk("rst_ovr", 32'(rx_overrun), 0);
    chk("rst_und", 32'(rx_underrun), 0);

    // Four channels: words land at E2 and E4.
    strobe(4'hF, 64'h4444_3333_2222_1111);
    tick(); chk("p4_e1_level", 32'(level), 0);
    tick(); chk("p4_e2_level", 32'(level), 1);
    tick(); chk("p4_e3_level", 32'(level), 1);
    tick(); chk("p4_e4_level", 32'(level), 2);
    read_word("p4_rd0", 32'h1111_2222, 1);
    read_word("p4_rd1", 32'h3333_4444, 0);
    tick();
    chk("p4_hold_valid", 32'(rd_valid), 0);
    chk("p4_hold_data", rd_data, 32'h3333_4444);

    // Sparse mask, then a single-channel strobe leaving a partial word.
    strobe(4'b0101, 64'h0000_BBBB_0000_AAAA);
    tick(); tick(); chk("sp_a_level", 32'(level), 1);
    strobe(4'b0101, 64'h0000_DDDD_0000_CCCC);
    tick(); tick(); chk("sp_c_level", 32'(level), 2);
    strobe(4'b0001, 64'h0000_0000_0000_1234);
    tick(); tick(); chk("sp_part_level", 32'(level), 2);
    read_word("sp_rd0", 32'hAAAA_BBBB, 1);
    read_word("sp_rd1", 32'hCCCC_DDDD, 0);

    reset = 1'b1; tick(); reset = 1'b0;

    // Strobe two cycles after the first is dropped.
    strobe(4'hF, 64'h4444_3333_2222_1111);
    tick();
    strobe(4'hF, 64'h8888_7777_6666_5555);
    chk("col_ovr", 32'(rx_overrun), 1);
    tick(); tick(); chk("col_level", 32'(level), 2);
    clear_status = 1'b1; tick(); clear_status = 1'b0;
    chk("col_clr", 32'(rx_overrun), 0);
    read_word("col_rd0", 32'h1111_2222, 1);
    read_word("col_rd1", 32'h3333_4444, 0);

    // Strobe four cycles after the first lands on the last-channel cycle and is kept.
    strobe(4'hF, 64'h4444_3333_2222_1111);
    tick(); tick(); tick();
    strobe(4'hF, 64'h8888_7777_6666_5555);
    chk("b2b_ovr", 32'(rx_overrun), 0);
    chk("b2b_e4_level", 32'(level), 2);
    tick(); tick(); tick(); tick();
    chk("b2b_e8_level", 32'(level), 4);
    chk("b2b_pkt", 32'(have_pkt_rdy), 1);

    // Full FIFO: fifth word dropped; then a push coinciding with a pop is kept.
    strobe(4'b0011, 64'h0000_0000_AAAA_9999);
    tick(); tick();
    chk("full_ovr", 32'(rx_overrun), 1);
    chk("full_level", 32'(level), 4);
    clear_status = 1'b1; tick(); clear_status = 1'b0;
    strobe(4'b0011, 64'h0000_0000_CCCC_BBBB);
    tick();
    read_word("full_rdpush", 32'h1111_2222, 4);
    chk("full_rp_ovr", 32'(rx_overrun), 0);

    // Packet-ready threshold around level 3.
    read_word("pkt_rd0", 32'h3333_4444, 3);
    chk("pkt_at3", 32'(have_pkt_rdy), 1);
    read_word("pkt_rd1", 32'h5555_6666, 2);
    chk("pkt_fall", 32'(have_pkt_rdy), 0);
    strobe(4'b0011, 64'h0000_0000_3434_1212);
    tick(); chk("pkt_e1", 32'(have_pkt_rdy), 0);
    tick(); chk("pkt_rise_lvl", 32'(level), 3);
    chk("pkt_rise", 32'(have_pkt_rdy), 1);
    read_word("drn_rd0", 32'h7777_8888, 2);
    read_word("drn_rd1", 32'hBBBB_CCCC, 1);
    read_word("drn_rd2", 32'h1212_3434, 0);
    rd_req = 1'b1; tick(); rd_req = 1'b0;
    chk("und_flag", 32'(rx_underrun), 1);
    chk("und_valid", 32'(rd_valid), 0);
    chk("und_data", rd_data, 32'h1212_3434);

    // Clear coinciding with a fresh underrun keeps the flag set.
    rd_req = 1'b1; clear_status = 1'b1; tick();
    rd_req = 1'b0; clear_status = 1'b0;
    chk("clr_vs_und", 32'(rx_underrun), 1);
    clear_status = 1'b1; tick(); clear_status = 1'b0;
    chk("clr_und", 32'(rx_underrun), 0);

    // Reset in the middle of a scan drops the partial sample.
    rx_overrun_setup();
    strobe(4'hF, 64'h4444_3333_2222_1111);
    tick();
    reset = 1'b1; tick(); reset = 1'b0;
    chk("mid_level", 32'(level), 0);
    chk("mid_rdata", rd_data, 0);
    chk("mid_ovr", 32'(rx_overrun), 0);
    chk("mid_pkt", 32'(have_pkt_rdy), 0);
    tick(); tick();
    chk("mid_idle_level", 32'(level), 0);
    strobe(4'b0011, 64'h0000_0000_A5A5_5A5A);
    tick(); tick();
    chk("mid_new_level", 32'(level), 1);
    read_word("mid_rd0", 32'h5A5A_A5A5, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

  // Raises rx_overrun with a colliding strobe so the mid-scan reset has a flag to clear.
  task automatic rx_overrun_setup();
    strobe(4'b0011, 64'h0000_0000_0F0F_F0F0);
    strobe(4'b0011, 64'h0000_0000_1111_2222);
    chk("mid_pre_ovr", 32'(rx_overrun), 1);
    tick();
  endtask
endmodule
